robot_nav_fsm: RTL and testbench
================================

// Module: robot_nav_fsm
// PURPOSE
//  Parametrised target-seek navigation FSM for the robot: N-zone pixel steering, distance/proximity stop,
//  timed search with abort, arrival confirmation. Sits between vision/ultrasonic front-end and motor driver;
//  overwrite flags the display mux to show navigation status instead of hex_data.
// PARAMETERS
//  N_ZONES        5           pixel_location width, bit0 = far right, MSB = far left; must be odd, >=3
//  DIST_W         8           distance width (cm, unsigned)
//  STOP_DIST      20          stop when distance < STOP_DIST
//  STOP_HYST      5           resume tracking only when distance >= STOP_DIST+STOP_HYST
//  SEARCH_TIMEOUT 50_000_000  cycles in SEARCH without target before ABORT (1 s @ 50 MHz)
//  LOST_CYCLES    5_000_000   consecutive no-target cycles in TRACK before falling back to SEARCH
//  ARRIVE_HOLD    25_000_000  cycles STOP must hold centred+close before ARRIVED
//  SPEED_W        4           motor_speed width; SPEED_MAX = 2**SPEED_W-1
// PORTS
//  CLOCK_50       in   1        system clock, single domain
//  reset          in   1        synchronous, active-high
//  bell           in   1        start request, 1-cycle pulse (already debounced)
//  abort_req      in   1        user abort pulse
//  ack            in   1        user acknowledge pulse (returns ARRIVED/ABORT to IDLE)
//  pixel_location in   N_ZONES  target zone mask, 0 = no target
//  distance       in   DIST_W   range reading, sampled every cycle
//  proximity      in   1        hard obstacle flag
//  motor_cmd      out  3        motor_cmd_t: STOP, FWD, TURN_L, TURN_R, SPIN_L
//  motor_speed    out  SPEED_W  speed to PWM stage
//  overwrite      out  1        display override, high in ARRIVED and ABORT
//  nav_state      out  3        nav_state_t of current state, debug/display
// BEHAVIOUR
//  Reset (sync, high): state IDLE, motor_cmd STOP, motor_speed 0, overwrite 0, all timers cleared.
//  Moore: outputs registered, updated on the same edge as the state register (1-cycle input->output latency).
//  Zone decode: centre = bit N_ZONES/2; centre bit set -> CENTRE; else any bit above -> LEFT; else any below -> RIGHT.
//  IDLE: STOP. bell -> SEARCH.
//  SEARCH: SPIN_L. pixel_location!=0 -> TRACK; timer reaches SEARCH_TIMEOUT-1 -> ABORT.
//  TRACK: CENTRE->FWD, LEFT->TURN_L, RIGHT->TURN_R, no target->keep last cmd.
//    proximity | distance<STOP_DIST -> STOP; LOST_CYCLES consecutive no-target -> SEARCH.
//  STOP: STOP. centred & distance<STOP_DIST for ARRIVE_HOLD consecutive cycles -> ARRIVED;
//    !proximity & distance>=STOP_DIST+STOP_HYST -> TRACK; hold counter clears whenever condition drops.
//  ARRIVED: STOP, overwrite=1. ack -> IDLE; bell ignored.
//  ABORT: STOP, overwrite=1. ack -> IDLE; bell -> SEARCH.
//  Priority per cycle: reset > abort_req (from SEARCH/TRACK/STOP -> ABORT) > proximity stop > lost/timeout > steering.
//  ack and bell same cycle in ABORT: ack wins. abort_req in IDLE/ARRIVED/ABORT ignored.
//  Timers saturate, never wrap; every timer clears on state entry.
//  distance compare in DIST_W+1 bits so STOP_DIST+STOP_HYST cannot overflow.
// CONFIGURATION
//  ROBOT_NAV_SPEED_RAMP_EN defined: motor_speed ramps +1 every 2**16 cycles up to SPEED_MAX while cmd is FWD;
//    TURN_*/SPIN_L use SPEED_MAX/2 immediately; any STOP resets ramp to 0.
//  Undefined: motor_speed = SPEED_MAX when cmd FWD, SPEED_MAX/2 for TURN_*/SPIN_L, 0 for STOP. Port present either way.
// STRUCTURE
//  robot_nav_pkg: nav_state_t {IDLE,SEARCH,TRACK,STOP,ARRIVED,ABORT}, motor_cmd_t, zone_t {NONE,LEFT,CENTRE,RIGHT}.
//  Sub-module robot_cycle_timer #(MAX): clr, en -> saturating count, done pulse at MAX-1;
//    instantiated three times (search, lost, arrive-hold).
// TESTING  (sim params: N_ZONES=5, SEARCH_TIMEOUT=16, LOST_CYCLES=4, ARRIVE_HOLD=3, STOP_DIST=20, STOP_HYST=5)
//  reset mid-TRACK with pixel=5'b00100 -> next edge IDLE, STOP, speed 0, overwrite 0.
//  bell, pixel=0 for 16 cycles -> SEARCH/SPIN_L, then ABORT, overwrite=1; bell -> SEARCH; ack+bell -> IDLE.
//  TRACK pixel 00100/01000/00010/00001 -> FWD/TURN_L/TURN_R/TURN_R; pixel=0 for 4 cycles -> SEARCH.
//  TRACK distance=19 -> STOP; distance=22 -> stays STOP; distance=25, proximity=0 -> TRACK.
//  STOP pixel=00100, distance=10 for 3 cycles -> ARRIVED, overwrite=1; 2 cycles then off-centre -> counter clears.
//  abort_req and proximity same cycle in TRACK -> ABORT; with RAMP_EN, FWD speed reaches 15 then drops to 0 on STOP.

Source files
------------

// File: rtl/robot_nav_pkg.sv
// Shared types for the robot navigation FSM: state, motor command and zone encodings.
package robot_nav_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    TRACK   = 3'd2,
    STOP    = 3'd3,
    ARRIVED = 3'd4,
    ABORT   = 3'd5
  } nav_state_t;

  typedef enum logic [2:0] {
    MC_STOP   = 3'd0,
    MC_FWD    = 3'd1,
    MC_TURN_L = 3'd2,
    MC_TURN_R = 3'd3,
    MC_SPIN_L = 3'd4
  } motor_cmd_t;

  typedef enum logic [1:0] {
    ZN_NONE   = 2'd0,
    ZN_LEFT   = 2'd1,
    ZN_CENTRE = 2'd2,
    ZN_RIGHT  = 2'd3
  } zone_t;

endpackage

// File: rtl/robot_cycle_timer.sv
// Saturating cycle counter: clr has priority, counts while en, done while en at count MAX-1.
module robot_cycle_timer #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CNT_W = (MAX > 1) ? $clog2(MAX) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign done = en && (cnt == LAST);

endmodule

// File: rtl/robot_nav_fsm.sv
// Target-seek navigation FSM with registered Moore outputs.
// Optional build macro ROBOT_NAV_SPEED_RAMP_EN enables a gradual forward speed ramp.
module robot_nav_fsm
  import robot_nav_pkg::*;
#(
  parameter int N_ZONES        = 5,
  parameter int DIST_W         = 8,
  parameter int STOP_DIST      = 20,
  parameter int STOP_HYST      = 5,
  parameter int SEARCH_TIMEOUT = 50_000_000,
  parameter int LOST_CYCLES    = 5_000_000,
  parameter int ARRIVE_HOLD    = 25_000_000,
  parameter int SPEED_W        = 4
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               bell,
  input  logic               abort_req,
  input  logic               ack,
  input  logic [N_ZONES-1:0] pixel_location,
  input  logic [DIST_W-1:0]  distance,
  input  logic               proximity,
  output motor_cmd_t         motor_cmd,
  output logic [SPEED_W-1:0] motor_speed,
  output logic               overwrite,
  output nav_state_t         nav_state
);

  localparam int CTR = N_ZONES / 2;
  localparam logic [SPEED_W-1:0] SPEED_MAX  = '1;
  localparam logic [SPEED_W-1:0] SPEED_HALF = SPEED_MAX >> 1;
  // One extra bit so STOP_DIST+STOP_HYST never wraps against an 8-bit reading.
  localparam logic [DIST_W:0] STOP_LIM   = (DIST_W+1)'(STOP_DIST);
  localparam logic [DIST_W:0] RESUME_LIM = (DIST_W+1)'(STOP_DIST + STOP_HYST);

  function automatic zone_t zone_decode(input logic [N_ZONES-1:0] px);
    zone_t z;
    z = ZN_NONE;
    if (px[CTR])                    z = ZN_CENTRE;
    else if (|px[N_ZONES-1:CTR+1])  z = ZN_LEFT;
    else if (|px[CTR-1:0])          z = ZN_RIGHT;
    return z;
  endfunction

  function automatic logic [SPEED_W-1:0] speed_for(input motor_cmd_t c);
    logic [SPEED_W-1:0] s;
    case (c)
      MC_FWD:                        s = SPEED_MAX;
      MC_TURN_L, MC_TURN_R, MC_SPIN_L: s = SPEED_HALF;
      default:                       s = '0;
    endcase
    return s;
  endfunction

  nav_state_t         state, state_next;
  motor_cmd_t         cmd_next;
  logic [SPEED_W-1:0] speed_next;
  zone_t              zone;
  logic [DIST_W:0]    dist_x;
  logic               too_close, clear_ahead, no_target, hold_cond;
  logic               search_done, lost_done, hold_done;

  assign zone        = zone_decode(pixel_location);
  assign dist_x      = {1'b0, distance};
  assign too_close   = dist_x < STOP_LIM;
  assign clear_ahead = !proximity && (dist_x >= RESUME_LIM);
  assign no_target   = (pixel_location == '0);
  assign hold_cond   = (zone == ZN_CENTRE) && too_close;

  // Timers are held clear outside their owning state, so each starts from zero on entry.
  robot_cycle_timer #(.MAX(SEARCH_TIMEOUT)) u_search_timer (
    .clk(CLOCK_50), .rst(reset), .clr(state != SEARCH),
    .en(state == SEARCH), .done(search_done)
  );

  robot_cycle_timer #(.MAX(LOST_CYCLES)) u_lost_timer (
    .clk(CLOCK_50), .rst(reset), .clr(state != TRACK || !no_target),
    .en(state == TRACK && no_target), .done(lost_done)
  );

  robot_cycle_timer #(.MAX(ARRIVE_HOLD)) u_hold_timer (
    .clk(CLOCK_50), .rst(reset), .clr(state != STOP || !hold_cond),
    .en(state == STOP && hold_cond), .done(hold_done)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bell) state_next = SEARCH;
      SEARCH: begin
        if (abort_req)        state_next = ABORT;
        else if (search_done) state_next = ABORT;
        else if (!no_target)  state_next = TRACK;
      end
      TRACK: begin
        if (abort_req)                   state_next = ABORT;
        else if (proximity || too_close) state_next = STOP;
        else if (lost_done)              state_next = SEARCH;
      end
      STOP: begin
        if (abort_req)        state_next = ABORT;
        else if (hold_done)   state_next = ARRIVED;
        else if (clear_ahead) state_next = TRACK;
      end
      ARRIVED: if (ack) state_next = IDLE;
      ABORT: begin
        if (ack)       state_next = IDLE;
        else if (bell) state_next = SEARCH;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_next = MC_STOP;
    case (state_next)
      SEARCH: cmd_next = MC_SPIN_L;
      TRACK: begin
        case (zone)
          ZN_CENTRE: cmd_next = MC_FWD;
          ZN_LEFT:   cmd_next = MC_TURN_L;
          ZN_RIGHT:  cmd_next = MC_TURN_R;
          default:   cmd_next = motor_cmd;
        endcase
      end
      default: cmd_next = MC_STOP;
    endcase
  end

`ifdef ROBOT_NAV_SPEED_RAMP_EN
  logic [15:0]        ramp_div;
  logic [SPEED_W-1:0] ramp_lvl;

  always_ff @(posedge CLOCK_50) begin
    if (reset || cmd_next == MC_STOP) begin
      ramp_div <= '0;
      ramp_lvl <= '0;
    end else if (cmd_next == MC_FWD) begin
      ramp_div <= ramp_div + 1'b1;
      if (ramp_div == '1 && ramp_lvl != SPEED_MAX)
        ramp_lvl <= ramp_lvl + 1'b1;
    end
  end

  assign speed_next = (cmd_next == MC_FWD) ? ramp_lvl : speed_for(cmd_next);
`else
  assign speed_next = speed_for(cmd_next);
`endif

  // Output register stage: outputs follow the next state on the same edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      motor_cmd   <= MC_STOP;
      motor_speed <= '0;
      overwrite   <= 1'b0;
    end else begin
      state       <= state_next;
      motor_cmd   <= cmd_next;
      motor_speed <= speed_next;
      overwrite   <= (state_next == ARRIVED) || (state_next == ABORT);
    end
  end

  assign nav_state = state;

endmodule

// File: tb/tb_robot_nav_fsm.sv
// Directed-vector bench for robot_nav_fsm with short timer parameters.
module tb_robot_nav_fsm;
  import robot_nav_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset, bell, abort_req, ack, proximity;
  logic [4:0] pixel_location;
  logic [7:0] distance;
  motor_cmd_t motor_cmd;
  logic [3:0] motor_speed;
  logic       overwrite;
  nav_state_t nav_state;

  int checks = 0;
  int errors = 0;

  robot_nav_fsm #(
    .N_ZONES(5), .DIST_W(8), .STOP_DIST(20), .STOP_HYST(5),
    .SEARCH_TIMEOUT(16), .LOST_CYCLES(4), .ARRIVE_HOLD(3), .SPEED_W(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .bell(bell), .abort_req(abort_req),
    .ack(ack), .pixel_location(pixel_location), .distance(distance),
    .proximity(proximity), .motor_cmd(motor_cmd), .motor_speed(motor_speed),
    .overwrite(overwrite), .nav_state(nav_state)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input nav_state_t st, input motor_cmd_t mc,
                           input int spd, input int ow);
    check({tag, ".state"}, int'(nav_state), int'(st));
    check({tag, ".cmd"},   int'(motor_cmd), int'(mc));
    check({tag, ".speed"}, int'(motor_speed), spd);
    check({tag, ".ovw"},   int'(overwrite), ow);
  endtask

  initial begin
    reset = 1'b1; bell = 1'b0; abort_req = 1'b0; ack = 1'b0; proximity = 1'b0;
    pixel_location = 5'b0; distance = 8'd100;
    tick(); tick();
    reset = 1'b0;
    check_out("reset", IDLE, MC_STOP, 0, 0);
    abort_req = 1'b1; tick(); abort_req = 1'b0;
    check_out("idle_abort_ignored", IDLE, MC_STOP, 0, 0);

    // Search timeout: 16 cycles spinning, then ABORT.
    bell = 1'b1; tick(); bell = 1'b0;
    check_out("search_enter", SEARCH, MC_SPIN_L, 7, 0);
    for (int i = 0; i < 15; i++) tick();
    check_out("search_last", SEARCH, MC_SPIN_L, 7, 0);
    tick();
    check_out("timeout", ABORT, MC_STOP, 0, 1);
    abort_req = 1'b1; tick(); abort_req = 1'b0;
    check_out("abort_ignored", ABORT, MC_STOP, 0, 1);
    bell = 1'b1; tick(); bell = 1'b0;
    check_out("abort_bell", SEARCH, MC_SPIN_L, 7, 0);
    abort_req = 1'b1; tick(); abort_req = 1'b0;
    check_out("search_abort", ABORT, MC_STOP, 0, 1);
    ack = 1'b1; bell = 1'b1; tick(); ack = 1'b0; bell = 1'b0;
    check_out("ack_wins", IDLE, MC_STOP, 0, 0);

    // Steering decode and lost-target fallback.
    bell = 1'b1; tick(); bell = 1'b0;
    pixel_location = 5'b00100; tick();
    check_out("trk_centre", TRACK, MC_FWD, 15, 0);
    pixel_location = 5'b01000; tick();
    check_out("trk_left", TRACK, MC_TURN_L, 7, 0);
    pixel_location = 5'b00010; tick();
    check_out("trk_right", TRACK, MC_TURN_R, 7, 0);
    pixel_location = 5'b00001; tick();
    check_out("trk_far_right", TRACK, MC_TURN_R, 7, 0);
    pixel_location = 5'b10000; tick();
    check_out("trk_far_left", TRACK, MC_TURN_L, 7, 0);
    pixel_location = 5'b0;
    for (int i = 0; i < 3; i++) tick();
    check_out("trk_keep_cmd", TRACK, MC_TURN_L, 7, 0);
    pixel_location = 5'b00100; tick();
    pixel_location = 5'b0;
    for (int i = 0; i < 3; i++) tick();
    check_out("lost_restart", TRACK, MC_FWD, 15, 0);
    tick();
    check_out("lost", SEARCH, MC_SPIN_L, 7, 0);

    // Distance stop with hysteresis and proximity.
    pixel_location = 5'b01000; tick();
    check_out("trk_again", TRACK, MC_TURN_L, 7, 0);
    distance = 8'd20; tick();
    check_out("dist_20_track", TRACK, MC_TURN_L, 7, 0);
    distance = 8'd19; tick();
    check_out("dist_19_stop", STOP, MC_STOP, 0, 0);
    distance = 8'd22; tick(); tick();
    check_out("dist_22_hold", STOP, MC_STOP, 0, 0);
    distance = 8'd24; tick();
    check_out("dist_24_hold", STOP, MC_STOP, 0, 0);
    distance = 8'd25; tick();
    check_out("dist_25_resume", TRACK, MC_TURN_L, 7, 0);
    distance = 8'd100; proximity = 1'b1; tick();
    check_out("prox_stop", STOP, MC_STOP, 0, 0);
    tick();
    check_out("prox_blocks", STOP, MC_STOP, 0, 0);
    proximity = 1'b0; tick();
    check_out("prox_clear", TRACK, MC_TURN_L, 7, 0);

    // Arrival hold, interrupted once by an off-centre target.
    pixel_location = 5'b00100; distance = 8'd10; tick();
    check_out("arrive_stop", STOP, MC_STOP, 0, 0);
    tick();
    pixel_location = 5'b01000; tick();
    pixel_location = 5'b00100; tick(); tick();
    check_out("hold_cleared", STOP, MC_STOP, 0, 0);
    tick();
    check_out("arrived", ARRIVED, MC_STOP, 0, 1);
    bell = 1'b1; abort_req = 1'b1; tick(); bell = 1'b0; abort_req = 1'b0;
    check_out("arrived_bell", ARRIVED, MC_STOP, 0, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    check_out("arrived_ack", IDLE, MC_STOP, 0, 0);

    // Abort beats proximity in TRACK.
    distance = 8'd100;
    bell = 1'b1; tick(); bell = 1'b0;
    tick();
    check_out("trk_pre_abort", TRACK, MC_FWD, 15, 0);
    abort_req = 1'b1; proximity = 1'b1; tick(); abort_req = 1'b0; proximity = 1'b0;
    check_out("abort_vs_prox", ABORT, MC_STOP, 0, 1);
    ack = 1'b1; tick(); ack = 1'b0;

    // Reset mid-TRACK.
    bell = 1'b1; tick(); bell = 1'b0;
    tick();
    check_out("trk_pre_reset", TRACK, MC_FWD, 15, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check_out("reset_mid", IDLE, MC_STOP, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
